// File: rtl/control_pkg.sv
// Shared encodings for the RV64I multicycle sequencer: FSM states, opcodes,
// ALU operation codes and datapath mux selects.
package control_pkg;

  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_MEMORY    = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_TRAP      = 3'd5
  } state_e;

  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;

  typedef enum logic [3:0] {
    CLS_OP, CLS_OP_IMM, CLS_OP_32, CLS_OP_IMM_32, CLS_LOAD, CLS_STORE,
    CLS_BRANCH, CLS_JAL, CLS_JALR, CLS_LUI, CLS_AUIPC, CLS_ILLEGAL
  } op_class_e;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_e;

  localparam logic [1:0] PC_SRC_PLUS4  = 2'b00;
  localparam logic [1:0] PC_SRC_ALU    = 2'b01;
  localparam logic [1:0] PC_SRC_BRANCH = 2'b10;

  localparam logic [1:0] SRC_A_RS1  = 2'b00;
  localparam logic [1:0] SRC_A_PC   = 2'b01;
  localparam logic [1:0] SRC_A_ZERO = 2'b10;

  localparam logic [1:0] SRC_B_RS2  = 2'b00;
  localparam logic [1:0] SRC_B_IMM  = 2'b01;
  localparam logic [1:0] SRC_B_FOUR = 2'b10;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  function automatic op_class_e classify(input logic [6:0] opcode);
    case (opcode)
      OPC_OP:        return CLS_OP;
      OPC_OP_IMM:    return CLS_OP_IMM;
      OPC_OP_32:     return CLS_OP_32;
      OPC_OP_IMM_32: return CLS_OP_IMM_32;
      OPC_LOAD:      return CLS_LOAD;
      OPC_STORE:     return CLS_STORE;
      OPC_BRANCH:    return CLS_BRANCH;
      OPC_JAL:       return CLS_JAL;
      OPC_JALR:      return CLS_JALR;
      OPC_LUI:       return CLS_LUI;
      OPC_AUIPC:     return CLS_AUIPC;
      default:       return CLS_ILLEGAL;
    endcase
  endfunction

endpackage

// File: rtl/alu_control.sv
// Combinational ALU operation decode from opcode class, funct3 and
// instruction bit 30.
module alu_control
  import control_pkg::*;
(
  input  op_class_e  op_class,
  input  logic [2:0] funct3,
  input  logic       bit30,
  output logic [3:0] alu_op,
  output logic       alu_word
);

  logic is_arith;
  logic is_rtype;

  assign is_arith = (op_class == CLS_OP) || (op_class == CLS_OP_IMM) ||
                    (op_class == CLS_OP_32) || (op_class == CLS_OP_IMM_32);
  assign is_rtype = (op_class == CLS_OP) || (op_class == CLS_OP_32);

  always_comb begin
    alu_op   = ALU_ADD;
    alu_word = 1'b0;
    if (is_arith) begin
      alu_word = (op_class == CLS_OP_32) || (op_class == CLS_OP_IMM_32);
      case (funct3)
        // bit30 on an immediate ADDI is just an immediate bit, never SUB
        3'b000:  alu_op = (is_rtype && bit30) ? ALU_SUB : ALU_ADD;
        3'b001:  alu_op = ALU_SLL;
        3'b010:  alu_op = ALU_SLT;
        3'b011:  alu_op = ALU_SLTU;
        3'b100:  alu_op = ALU_XOR;
        3'b101:  alu_op = bit30 ? ALU_SRA : ALU_SRL;
        3'b110:  alu_op = ALU_OR;
        default: alu_op = ALU_AND;
      endcase
    end else if (op_class == CLS_BRANCH) begin
      alu_op = ALU_SUB;
    end
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Five-phase RV64I sequencer driving all datapath enables and selects.
// Optional macro CTRL_MEM_WAIT_EN stalls FETCH/MEMORY until mem_ready.
module multicycle_control_unit
  import control_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instruction,
  input  logic        alu_zero,
  input  logic        alu_lt,
  input  logic        alu_ltu,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        ir_write,
  output logic        reg_write,
  output logic        imem_read,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic [1:0]  pc_src,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [3:0]  alu_op,
  output logic        alu_word,
  output logic [1:0]  wb_sel,
  output logic        instr_done,
  output logic        illegal_instr,
  output logic [2:0]  state
);

  state_e     state_q;
  state_e     state_d;
  op_class_e  op_class;
  logic [2:0] funct3;
  logic [3:0] alu_op_c;
  logic       alu_word_c;
  logic       branch_ok;
  logic       branch_taken;
  logic       mem_go;
  logic       unused_bits;

  assign op_class = classify(instruction[6:0]);
  assign funct3   = instruction[14:12];

`ifdef CTRL_MEM_WAIT_EN
  assign mem_go = mem_ready;
`else
  assign mem_go = 1'b1;
`endif

  // Register fields and immediates belong to the datapath, not to us.
  assign unused_bits = ^{instruction[31], instruction[29:15],
                         instruction[11:7], mem_ready, (XLEN > 0)};

  alu_control u_alu_control (
    .op_class (op_class),
    .funct3   (funct3),
    .bit30    (instruction[30]),
    .alu_op   (alu_op_c),
    .alu_word (alu_word_c)
  );

  assign branch_ok = (funct3 != 3'b010) && (funct3 != 3'b011);

  always_comb begin
    case (funct3)
      3'b000:  branch_taken = alu_zero;
      3'b001:  branch_taken = !alu_zero;
      3'b100:  branch_taken = alu_lt;
      3'b101:  branch_taken = !alu_lt;
      3'b110:  branch_taken = alu_ltu;
      3'b111:  branch_taken = !alu_ltu;
      default: branch_taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_FETCH;
    else       state_q <= state_d;
  end

  assign state = reset ? ST_FETCH : state_q;

  always_comb begin
    state_d       = state_q;
    pc_write      = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    imem_read     = 1'b0;
    dmem_read     = 1'b0;
    dmem_write    = 1'b0;
    pc_src        = PC_SRC_PLUS4;
    alu_src_a     = SRC_A_RS1;
    alu_src_b     = SRC_B_RS2;
    alu_op        = ALU_ADD;
    alu_word      = 1'b0;
    wb_sel        = WB_ALU;
    instr_done    = 1'b0;
    illegal_instr = 1'b0;

    if (reset) begin
      state_d = ST_FETCH;
    end else begin
      case (state_q)
        ST_FETCH: begin
          imem_read = 1'b1;
          if (mem_go) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            pc_src   = PC_SRC_PLUS4;
            state_d  = ST_DECODE;
          end
        end

        ST_DECODE: begin
          state_d = (op_class == CLS_ILLEGAL) ? ST_TRAP : ST_EXECUTE;
        end

        ST_EXECUTE: begin
          case (op_class)
            CLS_OP, CLS_OP_32: begin
              alu_op   = alu_op_c;
              alu_word = alu_word_c;
              state_d  = ST_WRITEBACK;
            end
            CLS_OP_IMM, CLS_OP_IMM_32: begin
              alu_op    = alu_op_c;
              alu_word  = alu_word_c;
              alu_src_b = SRC_B_IMM;
              state_d   = ST_WRITEBACK;
            end
            CLS_LOAD, CLS_STORE: begin
              alu_op    = alu_op_c;
              alu_src_b = SRC_B_IMM;
              state_d   = ST_MEMORY;
            end
            CLS_BRANCH: begin
              if (branch_ok) begin
                alu_op     = alu_op_c;
                pc_write   = branch_taken;
                pc_src     = branch_taken ? PC_SRC_BRANCH : PC_SRC_PLUS4;
                instr_done = 1'b1;
                state_d    = ST_FETCH;
              end else begin
                state_d = ST_TRAP;
              end
            end
            CLS_JAL: begin
              pc_write = 1'b1;
              pc_src   = PC_SRC_BRANCH;
              state_d  = ST_WRITEBACK;
            end
            CLS_JALR: begin
              alu_op    = alu_op_c;
              alu_src_b = SRC_B_IMM;
              pc_write  = 1'b1;
              pc_src    = PC_SRC_ALU;
              state_d   = ST_WRITEBACK;
            end
            CLS_LUI: begin
              alu_op    = alu_op_c;
              alu_src_a = SRC_A_ZERO;
              alu_src_b = SRC_B_IMM;
              state_d   = ST_WRITEBACK;
            end
            CLS_AUIPC: begin
              alu_op    = alu_op_c;
              alu_src_a = SRC_A_PC;
              alu_src_b = SRC_B_IMM;
              state_d   = ST_WRITEBACK;
            end
            default: state_d = ST_TRAP;
          endcase
        end

        ST_MEMORY: begin
          if (op_class == CLS_LOAD) begin
            dmem_read = 1'b1;
            if (mem_go) state_d = ST_WRITEBACK;
          end else begin
            dmem_write = 1'b1;
            if (mem_go) begin
              instr_done = 1'b1;
              state_d    = ST_FETCH;
            end
          end
        end

        ST_WRITEBACK: begin
          reg_write  = 1'b1;
          instr_done = 1'b1;
          state_d    = ST_FETCH;
          if (op_class == CLS_LOAD)
            wb_sel = WB_MEM;
          else if ((op_class == CLS_JAL) || (op_class == CLS_JALR))
            wb_sel = WB_PC4;
          else
            wb_sel = WB_ALU;
        end

        ST_TRAP: begin
          illegal_instr = 1'b1;
        end

        default: state_d = ST_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench for multicycle_control_unit: a per-instruction reference
// model queues the expected output vector for every cycle; a monitor compares.
module tb_multicycle_control_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] instruction = 32'h0;
  logic        alu_zero = 1'b0, alu_lt = 1'b0, alu_ltu = 1'b0, mem_ready = 1'b0;
  logic        pc_write, ir_write, reg_write, imem_read, dmem_read, dmem_write;
  logic [1:0]  pc_src, alu_src_a, alu_src_b, wb_sel;
  logic [3:0]  alu_op;
  logic        alu_word, instr_done, illegal_instr;
  logic [2:0]  state;

  always #5 clk = ~clk;

  multicycle_control_unit #(.XLEN(64)) dut (
    .clk(clk), .reset(reset), .instruction(instruction),
    .alu_zero(alu_zero), .alu_lt(alu_lt), .alu_ltu(alu_ltu), .mem_ready(mem_ready),
    .pc_write(pc_write), .ir_write(ir_write), .reg_write(reg_write),
    .imem_read(imem_read), .dmem_read(dmem_read), .dmem_write(dmem_write),
    .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .alu_word(alu_word), .wb_sel(wb_sel),
    .instr_done(instr_done), .illegal_instr(illegal_instr), .state(state)
  );

`ifdef CTRL_MEM_WAIT_EN
  localparam bit WAIT_BUILD = 1'b1;
`else
  localparam bit WAIT_BUILD = 1'b0;
`endif

  typedef struct packed {
    logic       pc_write, ir_write, reg_write, imem_read, dmem_read, dmem_write;
    logic [1:0] pc_src, alu_src_a, alu_src_b;
    logic [3:0] alu_op;
    logic       alu_word;
    logic [1:0] wb_sel;
    logic       instr_done, illegal_instr;
    logic [2:0] state;
  } out_t;

  typedef struct {
    logic        rst;
    logic        rdy;
    logic [31:0] ins;
    logic        z, lt, ltu;
    out_t        exp;
    string       tag;
  } cyc_t;

  cyc_t        plan[$];
  out_t        expq[$];
  string       tagq[$];
  int          checks = 0, passed = 0;
  logic [63:0] op_a, op_b;
  out_t        mon_got, mon_exp;
  string       mon_tag;

  // ---------------- reference model ----------------
  function automatic string kind_of(input logic [6:0] opc);
    case (opc)
      7'b0110011: return "alu_r";
      7'b0111011: return "alu_rw";
      7'b0010011: return "alu_i";
      7'b0011011: return "alu_iw";
      7'b0000011: return "load";
      7'b0100011: return "store";
      7'b1100011: return "branch";
      7'b1101111: return "jal";
      7'b1100111: return "jalr";
      7'b0110111: return "lui";
      7'b0010111: return "auipc";
      default:    return "bad";
    endcase
  endfunction

  function automatic logic [3:0] alu_code(input logic [2:0] f3, input logic b30, input bit is_r);
    string m;
    case (f3)
      3'd0: m = (is_r && b30) ? "sub" : "add";
      3'd1: m = "sll";
      3'd2: m = "slt";
      3'd3: m = "sltu";
      3'd4: m = "xor";
      3'd5: m = b30 ? "sra" : "srl";
      3'd6: m = "or";
      default: m = "and";
    endcase
    case (m)
      "add": return 4'd0;  "sub": return 4'd1;  "sll": return 4'd2;
      "slt": return 4'd3;  "sltu": return 4'd4; "xor": return 4'd5;
      "srl": return 4'd6;  "sra": return 4'd7;  "or": return 4'd8;
      default: return 4'd9;
    endcase
  endfunction

  function automatic bit taken_of(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] b);
    case (f3)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return $signed(a) <  $signed(b);
      3'd5: return $signed(a) >= $signed(b);
      3'd6: return a <  b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int wt(input int n);
    return WAIT_BUILD ? n : 0;
  endfunction

  // rdy_mode: 0 = hold mem_ready low, 1 = drive high, 2 = don't care
  task automatic push(input logic rst, input int rdy_mode, input logic [31:0] ins,
                      input out_t o, input string tag);
    cyc_t c;
    c.rst = rst;
    c.ins = ins;
    c.z   = (op_a == op_b);
    c.lt  = $signed(op_a) < $signed(op_b);
    c.ltu = op_a < op_b;
    if (!WAIT_BUILD || rdy_mode == 2) c.rdy = 1'($urandom_range(0, 1));
    else                              c.rdy = (rdy_mode == 1);
    c.exp = o;
    c.tag = tag;
    plan.push_back(c);
  endtask

  task automatic add_reset(input int n);
    for (int i = 0; i < n; i++) push(1'b1, 2, $urandom, '0, "reset");
  endtask

  task automatic add_trap(input logic [31:0] ins, input int n);
    out_t o;
    o = '0; o.state = 3'd5; o.illegal_instr = 1'b1;
    for (int i = 0; i < n; i++) push(1'b0, 2, ins, o, "trap");
    add_reset(2);
  endtask

  // eq_mode: 0 random operands, 1 rs1 == rs2, 2 rs1 != rs2
  task automatic add_instr(input logic [31:0] ins, input int fw, input int mw, input int eq_mode);
    out_t o;
    string k;
    logic [2:0] f3;
    op_a = {$urandom, $urandom};
    op_b = {$urandom, $urandom};
    if (eq_mode == 1 || (eq_mode == 0 && $urandom_range(0, 2) == 0)) op_b = op_a;
    if (eq_mode == 2) op_b = op_a ^ {32'h0, ($urandom | 32'h1)};
    k  = kind_of(ins[6:0]);
    f3 = ins[14:12];

    for (int i = 0; i < fw; i++) begin
      o = '0; o.imem_read = 1'b1;
      push(1'b0, 0, ins, o, "fetch_wait");
    end
    o = '0; o.imem_read = 1'b1; o.ir_write = 1'b1; o.pc_write = 1'b1;
    push(1'b0, 1, ins, o, "fetch");
    o = '0; o.state = 3'd1;
    push(1'b0, 2, ins, o, "decode");
    if (k == "bad") begin
      add_trap(ins, $urandom_range(10, 14));
      return;
    end

    o = '0; o.state = 3'd2;
    if (k == "branch" && (f3 == 3'd2 || f3 == 3'd3)) begin
      push(1'b0, 2, ins, o, "exec_badbr");
      add_trap(ins, $urandom_range(10, 14));
      return;
    end
    case (k)
      "alu_r", "alu_rw", "alu_i", "alu_iw": begin
        o.alu_op    = alu_code(f3, ins[30], (k == "alu_r" || k == "alu_rw"));
        o.alu_word  = (k == "alu_rw" || k == "alu_iw");
        o.alu_src_b = (k == "alu_i" || k == "alu_iw") ? 2'b01 : 2'b00;
      end
      "load", "store": o.alu_src_b = 2'b01;
      "branch": begin
        o.alu_op = 4'd1;
        if (taken_of(f3, op_a, op_b)) begin
          o.pc_write = 1'b1; o.pc_src = 2'b10;
        end
        o.instr_done = 1'b1;
      end
      "jal":   begin o.pc_write = 1'b1; o.pc_src = 2'b10; end
      "jalr":  begin o.pc_write = 1'b1; o.pc_src = 2'b01; o.alu_src_b = 2'b01; end
      "lui":   begin o.alu_src_a = 2'b10; o.alu_src_b = 2'b01; end
      default: begin o.alu_src_a = 2'b01; o.alu_src_b = 2'b01; end
    endcase
    push(1'b0, 2, ins, o, {"exec_", k});
    if (k == "branch") return;

    if (k == "load" || k == "store") begin
      o = '0; o.state = 3'd3;
      if (k == "load") o.dmem_read = 1'b1; else o.dmem_write = 1'b1;
      for (int i = 0; i < mw; i++) push(1'b0, 0, ins, o, "mem_wait");
      if (k == "store") o.instr_done = 1'b1;
      push(1'b0, 1, ins, o, {"mem_", k});
      if (k == "store") return;
    end

    o = '0; o.state = 3'd4; o.reg_write = 1'b1; o.instr_done = 1'b1;
    if (k == "load") o.wb_sel = 2'b01;
    else if (k == "jal" || k == "jalr") o.wb_sel = 2'b10;
    push(1'b0, 2, ins, o, {"wb_", k});
  endtask

  task automatic truncate_to(input int n);
    while (plan.size() > n) void'(plan.pop_back());
  endtask

  // ---------------- stimulus driver ----------------
  task automatic run_plan();
    cyc_t c;
    while (plan.size() > 0) begin
      c = plan.pop_front();
      @(posedge clk);
      #1;
      reset       = c.rst;
      instruction = c.ins;
      alu_zero    = c.z;
      alu_lt      = c.lt;
      alu_ltu     = c.ltu;
      mem_ready   = c.rdy;
      expq.push_back(c.exp);
      tagq.push_back(c.tag);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (expq.size() > 0) begin
      mon_got = {pc_write, ir_write, reg_write, imem_read, dmem_read, dmem_write,
                 pc_src, alu_src_a, alu_src_b, alu_op, alu_word, wb_sel,
                 instr_done, illegal_instr, state};
      mon_exp = expq.pop_front();
      mon_tag = tagq.pop_front();
      checks++;
      if (mon_got === mon_exp) passed++;
      else $display("FAIL %s: got %h required %h (t=%0t)", mon_tag, mon_got, mon_exp, $time);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    int n0, len;
    logic [6:0]  legal [11];
    logic [31:0] ins;
    legal = '{7'b0110011, 7'b0010011, 7'b0111011, 7'b0011011, 7'b0000011, 7'b0100011,
              7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};

    add_reset(3);
    add_instr(32'h03220293, 0, 0, 0);          // addi x5,x4,50
    add_instr(32'h00802303, 0, 0, 0);          // lw x6,8(x0)
    add_instr(32'h00000063, 0, 0, 1);          // beq taken
    add_instr(32'h00000063, 0, 0, 2);          // beq not taken
    add_instr(32'h3a4000ef, 0, 0, 0);          // jal
    add_instr(32'h40000033, 0, 0, 0);          // sub
    add_instr(32'h4050d093, 0, 0, 0);          // srai
    add_instr(32'h000000b7, 0, 0, 0);          // lui
    add_instr(32'h00000000, 0, 0, 0);          // illegal -> trap, then reset
    add_instr(32'h00002063, 0, 0, 0);          // branch funct3 010 -> trap
    add_instr(32'h03220293, wt(3), 0, 0);      // fetch held for 3 wait cycles
    n0 = plan.size();
    add_instr(32'h00502423, 0, wt(2), 0);      // sw, reset lands in MEMORY
    truncate_to(n0 + 3 + wt(1));
    add_reset(2);
    add_instr(32'h00802303, wt(1), wt(2), 0);
    run_plan();

    for (int i = 0; i < 250; i++) begin
      ins = $urandom;
      if ($urandom_range(0, 19) != 0) ins[6:0] = legal[$urandom_range(0, 10)];
      n0 = plan.size();
      add_instr(ins, wt($urandom_range(0, 3)), wt($urandom_range(0, 3)), 0);
      if ($urandom_range(0, 9) == 0) begin
        len = plan.size() - n0;
        truncate_to(n0 + $urandom_range(1, len - 1));
        add_reset($urandom_range(1, 3));
      end
      run_plan();
    end

    @(negedge clk);
    #1;
    checks++;
    if (expq.size() == 0) passed++;
    else $display("FAIL drain: %0d expected cycles left unchecked, required 0", expq.size());
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
